mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle main controller for the MIPS datapath. It decodes the instruction register's `op`/`funct` fields and steps a FETCH/DECODE/EXEC/MEM/WB state machine. Each cycle it drives the datapath enables and selects. `reg_dst` feeds the 5-bit write-address select directly: 0 selects rt, 1 selects rd. `link` overrides that address to $31 downstream.

## Interface
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: IR[31:26]. Stable from the end of FETCH until the next FETCH.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU equality flag, valid in EXEC.
- `pc_we` out 1: PC write enable.
- `ir_we` out 1: IR write enable.
- `reg_we` out 1: GRF write enable.
- `mem_we` out 1: DM write enable.
- `reg_dst` out 1: write-address select. 0 = rt, 1 = rd.
- `link` out 1: forces the write address to 31 (jal).
- `alu_src` out 1: ALU B operand. 0 = rt data, 1 = extended immediate.
- `alu_op` out 3: 0 ADD, 1 SUB, 2 OR, 3 PASSB. Other codes unused.
- `ext_op` out 2: 0 zero-extend, 1 sign-extend, 2 imm<<16.
- `npc_sel` out 2: 0 PC+4, 1 branch target, 2 jump target, 3 rs (jr).
- `wd_sel` out 2: 0 ALU result, 1 DM read data, 2 PC (already PC+4).
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `state` out 3: current state, for debug. FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

## Operation
- Decoded instructions:
  - R-type (op=0): addu (funct 0x21), subu (0x23), jr (0x08).
  - I-type: ori 0x0d, lw 0x23, sw 0x2b, beq 0x04, lui 0x0f.
  - J-type: j 0x02, jal 0x03.
- Any other op, or op=0 with another funct (including sll-nop 0x00), is a NOP. It completes in DECODE with no side effects.
- Structure: the state register is the only sequential element. All outputs are combinational from `state`, `op`, `funct` and `zero`.
- Default for every output in every state is 0, unless a rule below sets it.
- FETCH: `ir_we`=1, `pc_we`=1, `npc_sel`=0. Next state DECODE.
- DECODE:
  - j: `pc_we`=1, `npc_sel`=2.
  - jal: `pc_we`=1, `npc_sel`=2, `reg_we`=1, `link`=1, `wd_sel`=2.
  - jr: `pc_we`=1, `npc_sel`=3.
  - NOP: no outputs asserted.
  - j, jal, jr and NOP all assert `instr_done` and go to FETCH. Every other instruction goes to EXEC.
- EXEC:
  - addu: `alu_op`=0, `alu_src`=0.
  - subu: `alu_op`=1, `alu_src`=0.
  - ori: `alu_op`=2, `alu_src`=1, `ext_op`=0.
  - lui: `alu_op`=3, `alu_src`=1, `ext_op`=2.
  - lw/sw: `alu_op`=0, `alu_src`=1, `ext_op`=1.
  - beq: `alu_op`=1, `alu_src`=0, `ext_op`=1, `npc_sel`=1, `pc_we`=`zero`, `instr_done`=1. Next state FETCH.
  - lw/sw go to MEM. addu/subu/ori/lui go to WB.
- EXEC control values (`alu_op`, `alu_src`, `ext_op`) are held in MEM and WB, so the address and ALU result stay stable.
- MEM:
  - sw: `mem_we`=1, `instr_done`=1. Next state FETCH.
  - lw: next state WB.
- WB:
  - `reg_we`=1 and `instr_done`=1. Next state FETCH.
  - `reg_dst`=1 for addu/subu and 0 for ori/lui/lw.
  - `wd_sel`=1 for lw, 0 otherwise.
- Illegal `state` encodings (5–7) go to FETCH on the next edge with all outputs 0.

## Timing
- Reset: while `reset`=1, every write enable and `instr_done` is forced to 0. Those outputs are gated by `reset`, not only by state.
- The edge that samples `reset`=1 loads `state`=FETCH. The first fetch occurs on the first edge after `reset` drops.
- Reset asserted mid-instruction aborts it: no `reg_we` or `mem_we` is issued on the reset edge, and `state` returns to FETCH.
- Cycles per instruction:
  - j, jal, jr, NOP: 2.
  - beq: 3.
  - sw, addu, subu, ori, lui: 4.
  - lw: 5.
- Exactly one `pc_we` pulse per FETCH. At most one additional pulse per instruction (jump, or beq taken).
- `zero` is sampled combinationally only in EXEC for beq. It is ignored in all other states.

## Test plan
- Reset: hold `reset` 3 cycles with op=0x23 → enables and `instr_done` stay 0, `state`=0. After release: `ir_we`=1, `pc_we`=1 in the first cycle.
- lw (op 0x23) → states 0,1,2,3,4.
  - EXEC: `alu_src`=1, `ext_op`=1.
  - WB: `reg_we`=1, `reg_dst`=0, `wd_sel`=1, `instr_done`=1.
  - Total 5 cycles.
- addu (op 0, funct 0x21) → states 0,1,2,4. WB: `reg_dst`=1, `wd_sel`=0.
  - Follow with sw (0x2b) → MEM: `mem_we`=1, `reg_we`=0 throughout.
- beq (op 0x04) → EXEC `pc_we`=1, `npc_sel`=1 with `zero`=1; EXEC `pc_we`=0 with `zero`=0. 3 cycles each.
- jal (0x03) → DECODE: `pc_we`=1, `npc_sel`=2, `reg_we`=1, `link`=1, `wd_sel`=2. Then jr (op 0, funct 0x08) → `npc_sel`=3. Both 2 cycles.
- Undefined op 0x3f, and sll-nop → 2 cycles, no `reg_we`/`mem_we`. `reset` pulsed during lw's MEM → no `reg_we`, next cycle `state`=FETCH.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main controller: decodes op/funct and sequences FETCH/DECODE/EXEC/MEM/WB,
// driving datapath enables and selects combinationally from the current state.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_we,
    output logic       reg_dst,
    output logic       link,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic [1:0] npc_sel,
    output logic [1:0] wd_sel,
    output logic       instr_done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic is_rtype, is_addu, is_subu, is_jr;
    logic is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal, is_nop;
    logic [2:0] ex_alu_op;
    logic       ex_alu_src;
    logic [1:0] ex_ext_op;

    assign is_rtype = (op == 6'h00);
    assign is_addu  = is_rtype && (funct == 6'h21);
    assign is_subu  = is_rtype && (funct == 6'h23);
    assign is_jr    = is_rtype && (funct == 6'h08);
    assign is_ori   = (op == 6'h0d);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2b);
    assign is_beq   = (op == 6'h04);
    assign is_lui   = (op == 6'h0f);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);
    assign is_nop   = !(is_addu || is_subu || is_jr || is_ori || is_lw ||
                        is_sw || is_beq || is_lui || is_j || is_jal);

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    // ALU controls chosen in EXEC and held through MEM/WB so address and result stay stable
    always_comb begin
        ex_alu_op  = 3'd0;
        ex_alu_src = 1'b0;
        ex_ext_op  = 2'd0;
        if (is_subu || is_beq)
            ex_alu_op = 3'd1;
        else if (is_ori)
            ex_alu_op = 3'd2;
        else if (is_lui)
            ex_alu_op = 3'd3;
        if (is_ori || is_lui || is_lw || is_sw)
            ex_alu_src = 1'b1;
        if (is_lw || is_sw || is_beq)
            ex_ext_op = 2'd1;
        else if (is_lui)
            ex_ext_op = 2'd2;
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        reg_dst    = 1'b0;
        link       = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'd0;
        ext_op     = 2'd0;
        npc_sel    = 2'd0;
        wd_sel     = 2'd0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_we   = 1'b1;
                    npc_sel = 2'd2;
                end
                if (is_jal) begin
                    reg_we = 1'b1;
                    link   = 1'b1;
                    wd_sel = 2'd2;
                end
                if (is_jr) begin
                    pc_we   = 1'b1;
                    npc_sel = 2'd3;
                end
                if (is_j || is_jal || is_jr || is_nop)
                    instr_done = 1'b1;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_op  = ex_alu_op;
                alu_src = ex_alu_src;
                ext_op  = ex_ext_op;
                if (is_beq) begin
                    npc_sel    = 2'd1;
                    pc_we      = zero;
                    instr_done = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_addu || is_subu || is_ori || is_lui) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_op  = ex_alu_op;
                alu_src = ex_alu_src;
                ext_op  = ex_ext_op;
                if (is_sw) begin
                    mem_we     = 1'b1;
                    instr_done = 1'b1;
                end else if (is_lw) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                alu_op     = ex_alu_op;
                alu_src    = ex_alu_src;
                ext_op     = ex_ext_op;
                reg_we     = 1'b1;
                instr_done = 1'b1;
                reg_dst    = is_addu || is_subu;
                wd_sel     = is_lw ? 2'd1 : 2'd0;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset aborts any write in flight, independent of the state decode
        if (reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_we     = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: directed instruction table, mid-instruction reset, and a randomized
// instruction stream, all checked cycle by cycle against a per-instruction-class reference model.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we, ir_we, reg_we, mem_we, reg_dst, link, alu_src, instr_done;
    logic [2:0] alu_op;
    logic [1:0] ext_op, npc_sel, wd_sel;
    logic [2:0] state;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_we;
        logic       reg_dst;
        logic       link;
        logic       alu_src;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic [1:0] npc_sel;
        logic [1:0] wd_sel;
        logic       instr_done;
        logic [2:0] state;
    } outs_t;

    typedef enum int {C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL} cls_t;
    typedef int iq_t[$];

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         zmode;
        string      name;
        int         cycles;
    } vec_t;

    outs_t got;
    int    ncmp = 0;
    int    nfail = 0;

    assign got = {pc_we, ir_we, reg_we, mem_we, reg_dst, link, alu_src, alu_op,
                  ext_op, npc_sel, wd_sel, instr_done, state};

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
        .reg_dst(reg_dst), .link(link), .alu_src(alu_src), .alu_op(alu_op),
        .ext_op(ext_op), .npc_sel(npc_sel), .wd_sel(wd_sel),
        .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: begin
                case (f)
                    6'h21:   return C_ADDU;
                    6'h23:   return C_SUBU;
                    6'h08:   return C_JR;
                    default: return C_NOP;
                endcase
            end
            6'h0d:   return C_ORI;
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h04:   return C_BEQ;
            6'h0f:   return C_LUI;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_NOP;
        endcase
    endfunction

    // Visited state numbers for each instruction class, one entry per cycle
    function automatic iq_t seq_of(input cls_t c);
        case (c)
            C_LW:                      return '{0, 1, 2, 3, 4};
            C_SW:                      return '{0, 1, 2, 3};
            C_BEQ:                     return '{0, 1, 2};
            C_ADDU, C_SUBU, C_ORI, C_LUI: return '{0, 1, 2, 4};
            default:                   return '{0, 1};
        endcase
    endfunction

    function automatic outs_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int ph);
        outs_t e;
        cls_t  c;
        iq_t   seq;
        int    st;
        e   = '0;
        c   = classify(o, f);
        seq = seq_of(c);
        if (ph >= seq.size()) begin
            e.state = 3'd7;
            return e;
        end
        st = seq[ph];
        e.state      = 3'(st);
        e.instr_done = (ph == seq.size() - 1);
        if (st >= 2) begin
            case (c)
                C_ADDU: begin e.alu_op = 3'd0; e.alu_src = 1'b0; e.ext_op = 2'd0; end
                C_SUBU: begin e.alu_op = 3'd1; e.alu_src = 1'b0; e.ext_op = 2'd0; end
                C_ORI:  begin e.alu_op = 3'd2; e.alu_src = 1'b1; e.ext_op = 2'd0; end
                C_LUI:  begin e.alu_op = 3'd3; e.alu_src = 1'b1; e.ext_op = 2'd2; end
                C_LW, C_SW: begin e.alu_op = 3'd0; e.alu_src = 1'b1; e.ext_op = 2'd1; end
                C_BEQ:  begin e.alu_op = 3'd1; e.alu_src = 1'b0; e.ext_op = 2'd1; end
                default: ;
            endcase
        end
        case (st)
            0: begin e.pc_we = 1'b1; e.ir_we = 1'b1; end
            1: begin
                if (c == C_J || c == C_JAL) begin e.pc_we = 1'b1; e.npc_sel = 2'd2; end
                if (c == C_JAL) begin e.reg_we = 1'b1; e.link = 1'b1; e.wd_sel = 2'd2; end
                if (c == C_JR) begin e.pc_we = 1'b1; e.npc_sel = 2'd3; end
            end
            2: if (c == C_BEQ) begin e.npc_sel = 2'd1; e.pc_we = z; end
            3: if (c == C_SW) e.mem_we = 1'b1;
            4: begin
                e.reg_we  = 1'b1;
                e.reg_dst = (c == C_ADDU || c == C_SUBU);
                e.wd_sel  = (c == C_LW) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input outs_t exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int exp);
        ncmp++;
        if (actual != exp) begin
            nfail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, exp);
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH until instr_done; zmode 0/1 fixes zero, 2 randomizes it every cycle
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input int zmode,
                                 input string name, input int expcyc);
        int   cyc;
        logic done;
        iq_t  seq;
        op   = o;
        funct = f;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 8) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            @(negedge clk);
            checkOutput($sformatf("%s ph%0d", name, cyc), model(o, f, zero, cyc));
            done = instr_done;
            cyc++;
            @(posedge clk); #1;
        end
        seq = seq_of(classify(o, f));
        checkCount({name, " cycles"}, cyc, (expcyc < 0) ? seq.size() : expcyc);
        if (!done)
            pulseReset();
    endtask

    vec_t vecs[$];

    initial begin
        outs_t       exp;
        logic [5:0]  ro, rf;

        vecs = '{
            '{6'h23, 6'h00, 0, "lw",      5},
            '{6'h00, 6'h21, 0, "addu",    4},
            '{6'h2b, 6'h00, 0, "sw",      4},
            '{6'h04, 6'h00, 1, "beq_t",   3},
            '{6'h04, 6'h00, 0, "beq_nt",  3},
            '{6'h03, 6'h00, 0, "jal",     2},
            '{6'h00, 6'h08, 0, "jr",      2},
            '{6'h3f, 6'h00, 1, "undef",   2},
            '{6'h00, 6'h00, 1, "sll_nop", 2},
            '{6'h0d, 6'h00, 1, "ori",     4},
            '{6'h0f, 6'h00, 0, "lui",     4},
            '{6'h00, 6'h23, 1, "subu",    4},
            '{6'h02, 6'h00, 1, "j",       2}
        };

        reset = 1'b1;
        op    = 6'h23;
        funct = 6'h00;
        zero  = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset%0d", i), outs_t'(0));
            @(posedge clk); #1;
        end
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].zmode, vecs[i].name, vecs[i].cycles);

        // Reset during lw's MEM cycle: no register write may follow, and FETCH resumes
        op    = 6'h23;
        funct = 6'h00;
        zero  = 1'b0;
        for (int ph = 0; ph < 3; ph++) begin
            @(negedge clk);
            checkOutput($sformatf("lw_abort ph%0d", ph), model(op, funct, zero, ph));
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        exp = model(op, funct, zero, 3);
        exp.pc_we = 1'b0; exp.ir_we = 1'b0; exp.reg_we = 1'b0;
        exp.mem_we = 1'b0; exp.instr_done = 1'b0;
        checkOutput("lw_abort rst", exp);
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus(6'h00, 6'h21, 2, "after_abort", 4);

        for (int n = 0; n < 40; n++) begin
            rf = 6'h00;
            case ($urandom_range(0, 11))
                0:  begin ro = 6'h00; rf = 6'h21; end
                1:  begin ro = 6'h00; rf = 6'h23; end
                2:  begin ro = 6'h00; rf = 6'h08; end
                3:  begin ro = 6'h00; rf = 6'($urandom_range(0, 63)); end
                4:  ro = 6'h0d;
                5:  ro = 6'h23;
                6:  ro = 6'h2b;
                7:  ro = 6'h04;
                8:  ro = 6'h0f;
                9:  ro = 6'h02;
                10: ro = 6'h03;
                default: begin ro = 6'($urandom_range(0, 63)); rf = 6'($urandom_range(0, 63)); end
            endcase
            applyStimulus(ro, rf, 2, $sformatf("rnd%0d_op%02h_f%02h", n, ro, rf), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
